// File: rtl/hydra_pkg.sv
// hydra_pkg: shared FSM state type, header field widths and header packing
package hydra_pkg;

  localparam int HDR_LEN_W  = 9;
  localparam int HDR_PRIO_W = 3;
  localparam int HDR_PORT_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_HDR, S_DATA, S_EOP, S_GAP} state_e;

  // Header word is {pad, len, prio, dest} with dest in the LSBs
  function automatic logic [63:0] hdr_pack(input logic [31:0] len, input logic [31:0] prio,
                                           input logic [31:0] dest, input int prio_w,
                                           input int port_w);
    return (64'(len) << (prio_w + port_w)) | (64'(prio) << port_w) | 64'(dest);
  endfunction

endpackage

// File: rtl/hydra_pkt_gen_port.sv
// hydra_pkt_gen_port: one packet-generator channel with registered write outputs
module hydra_pkt_gen_port import hydra_pkg::*; #(
  parameter int DATA_W   = 16,
  parameter int LEN_W    = HDR_LEN_W,
  parameter int PRIO_W   = HDR_PRIO_W,
  parameter int PORT_W   = HDR_PORT_W,
  parameter int CNT_W    = 16,
  parameter int PORT_IDX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [PRIO_W-1:0] cfg_prio,
  input  logic [PORT_W-1:0] cfg_dest,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_pkts,
  input  logic [3:0]        cfg_gap,
  output logic              wr_sop,
  output logic              wr_eop,
  output logic              wr_vld,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    idx_q, idx_d, len_q, len_d;
  logic [3:0]          gap_q, gap_d, gapcfg_q, gapcfg_d;
  logic                stop_q, stop_d;
  logic [PRIO_W-1:0]   prio_q, prio_d, prio_r;
  logic [PORT_W-1:0]   dest_q, dest_d, dest_r;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    pkts_q, pkts_d, cnt_q, cnt_d;
  logic                wr_sop_q, wr_sop_d, wr_eop_q, wr_eop_d, wr_vld_q, wr_vld_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                last, pend, emit;

  // Header fields rotate with the packet index (packets completed so far)
  assign prio_r = mode_q[1] ? prio_q + PRIO_W'(cnt_q) : prio_q;
  assign dest_r = mode_q[0] ? dest_q + PORT_W'(cnt_q) : dest_q;
  assign last   = (len_q == '0) || (idx_q + 1'b1 == len_q);
  assign pend   = stop_q | stop;

  // Next state; a word counts as delivered only when it was presented with vld
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    stop_d   = stop_q | (stop && state_q != S_IDLE);
    len_d    = len_q;
    prio_d   = prio_q;
    dest_d   = dest_q;
    mode_d   = mode_q;
    pkts_d   = pkts_q;
    gapcfg_d = gapcfg_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    unique case (state_q)
      S_IDLE: if (start && !pause) begin
        state_d  = S_SOP;
        len_d    = cfg_len;
        prio_d   = cfg_prio;
        dest_d   = cfg_dest;
        mode_d   = cfg_mode;
        pkts_d   = cfg_pkts;
        gapcfg_d = cfg_gap;
        cnt_d    = '0;
        done_d   = 1'b0;
        stop_d   = 1'b0;
      end
      S_SOP: state_d = S_HDR;
      S_HDR: if (wr_vld_q) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: if (wr_vld_q) begin
        state_d = last ? S_EOP : S_DATA;
        idx_d   = last ? idx_q : idx_q + 1'b1;
      end
      S_EOP: begin
        cnt_d = cnt_q + 1'b1;
        if ((pkts_q != '0 && cnt_d == pkts_q) || pend) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = (gapcfg_q == '0 && !pause) ? S_SOP : S_GAP;
          gap_d   = gapcfg_q;
        end
      end
      S_GAP: if (!pause) begin
        gap_d   = gap_q > 4'd1 ? gap_q - 4'd1 : gap_q;
        state_d = gap_q > 4'd1 ? S_GAP : pend ? S_IDLE : S_SOP;
        done_d  = done_q | (gap_q <= 4'd1 && pend);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state
  always_comb begin
    emit      = (state_d == S_HDR || state_d == S_DATA) && !pause;
    wr_sop_d  = state_d == S_SOP;
    wr_eop_d  = state_d == S_EOP;
    wr_vld_d  = emit;
    busy_d    = state_d != S_IDLE;
    wr_data_d = !emit ? '0 :
                state_d == S_HDR ? DATA_W'(hdr_pack(32'(len_q), 32'(prio_r), 32'(dest_r), PRIO_W, PORT_W)) :
                DATA_W'({PORT_W'(PORT_IDX), idx_d});
  end

  // State, latched config and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      stop_q    <= 1'b0;
      len_q     <= '0;
      prio_q    <= '0;
      dest_q    <= '0;
      mode_q    <= '0;
      pkts_q    <= '0;
      gapcfg_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_sop_q  <= 1'b0;
      wr_eop_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      stop_q    <= stop_d;
      len_q     <= len_d;
      prio_q    <= prio_d;
      dest_q    <= dest_d;
      mode_q    <= mode_d;
      pkts_q    <= pkts_d;
      gapcfg_q  <= gapcfg_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wr_sop_q  <= wr_sop_d;
      wr_eop_q  <= wr_eop_d;
      wr_vld_q  <= wr_vld_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_sop   = wr_sop_q;
  assign wr_eop   = wr_eop_q;
  assign wr_vld   = wr_vld_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = cnt_q;

endmodule

// File: rtl/hydra_pkt_gen.sv
// hydra_pkt_gen: array of independent packet-generator channels
module hydra_pkt_gen import hydra_pkg::*; #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = HDR_LEN_W,
  parameter int PRIO_W    = HDR_PRIO_W,
  parameter int PORT_W    = HDR_PORT_W,
  parameter int CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             start,
  input  logic [NUM_PORTS-1:0]             stop,
  input  logic [NUM_PORTS-1:0][LEN_W-1:0]  cfg_len,
  input  logic [NUM_PORTS-1:0][PRIO_W-1:0] cfg_prio,
  input  logic [NUM_PORTS-1:0][PORT_W-1:0] cfg_dest,
  input  logic [NUM_PORTS-1:0][1:0]        cfg_mode,
  input  logic [NUM_PORTS-1:0][CNT_W-1:0]  cfg_pkts,
  input  logic [NUM_PORTS-1:0][3:0]        cfg_gap,
  input  logic [NUM_PORTS-1:0]             pause,
  output logic [NUM_PORTS-1:0]             wr_sop,
  output logic [NUM_PORTS-1:0]             wr_eop,
  output logic [NUM_PORTS-1:0]             wr_vld,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] wr_data,
  output logic [NUM_PORTS-1:0]             busy,
  output logic [NUM_PORTS-1:0]             done,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]  sent_cnt
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    hydra_pkt_gen_port #(
      .DATA_W(DATA_W), .LEN_W(LEN_W), .PRIO_W(PRIO_W), .PORT_W(PORT_W),
      .CNT_W(CNT_W), .PORT_IDX(i)
    ) u_port (
      .clk(clk), .rst_n(rst_n), .start(start[i]), .stop(stop[i]), .pause(pause[i]),
      .cfg_len(cfg_len[i]), .cfg_prio(cfg_prio[i]), .cfg_dest(cfg_dest[i]),
      .cfg_mode(cfg_mode[i]), .cfg_pkts(cfg_pkts[i]), .cfg_gap(cfg_gap[i]),
      .wr_sop(wr_sop[i]), .wr_eop(wr_eop[i]), .wr_vld(wr_vld[i]), .wr_data(wr_data[i]),
      .busy(busy[i]), .done(done[i]), .sent_cnt(sent_cnt[i])
    );
  end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// tb_hydra_pkt_gen: directed and randomized checks against a packet-stream model
module tb_hydra_pkt_gen;

  localparam int NP = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       start, stop, pause, rmask;
  logic [NP-1:0][8:0]  cfg_len;
  logic [NP-1:0][2:0]  cfg_prio;
  logic [NP-1:0][3:0]  cfg_dest;
  logic [NP-1:0][1:0]  cfg_mode;
  logic [NP-1:0][15:0] cfg_pkts;
  logic [NP-1:0][3:0]  cfg_gap;
  logic [NP-1:0]       wr_sop, wr_eop, wr_vld, busy, done;
  logic [NP-1:0][15:0] wr_data, sent_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q [NP][$];
  int sop_prev [NP];
  int sop_gap [NP];

  hydra_pkt_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_len(cfg_len),
    .cfg_prio(cfg_prio), .cfg_dest(cfg_dest), .cfg_mode(cfg_mode), .cfg_pkts(cfg_pkts),
    .cfg_gap(cfg_gap), .pause(pause), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_data(wr_data), .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header: len above prio above dest, rotating fields advance by packet index
  function automatic int hdr_of(input int p, input int k);
    int d, r;
    d = cfg_mode[p][0] ? (int'(cfg_dest[p]) + k) % 16 : int'(cfg_dest[p]);
    r = cfg_mode[p][1] ? (int'(cfg_prio[p]) + k) % 8 : int'(cfg_prio[p]);
    return int'(cfg_len[p]) * 128 + r * 16 + d;
  endfunction

  // Stream of events per packet: -1 = sop, header, payload words, -2 = eop
  task automatic expect_pkts(input int p, input int n);
    int l;
    l = cfg_len[p] == 0 ? 1 : int'(cfg_len[p]);
    for (int k = 0; k < n; k++) begin
      exp_q[p].push_back(-1);
      exp_q[p].push_back(hdr_of(p, k));
      for (int i = 0; i < l; i++) exp_q[p].push_back(p * 512 + i);
      exp_q[p].push_back(-2);
    end
  endtask

  task automatic pop_chk(input int p, input int obs, input string tag);
    int e;
    e = -3;
    if (exp_q[p].size() != 0) e = exp_q[p].pop_front();
    chk($sformatf("%s[%0d]", tag, p), obs, e);
  endtask

  task automatic tick();
    pause = (pause & ~rmask) | (16'($urandom) & rmask & ~start);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (wr_sop[p]) begin
        if (sop_prev[p] >= 0) sop_gap[p] = cyc - sop_prev[p];
        sop_prev[p] = cyc;
        pop_chk(p, -1, "sop");
      end
      if (wr_vld[p]) pop_chk(p, int'(wr_data[p]), "word");
      else chk($sformatf("idle_data[%0d]", p), wr_data[p], 0);
      if (wr_eop[p]) pop_chk(p, -2, "eop");
    end
  endtask

  task automatic wait_idle(input logic [NP-1:0] m, input int budget);
    int n;
    n = 0;
    while ((busy & m) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'((busy & m) != 0), 0);
  endtask

  task automatic fin(input int p, input int n);
    chk($sformatf("done[%0d]", p), done[p], 1);
    chk($sformatf("sent_cnt[%0d]", p), sent_cnt[p], n);
    chk($sformatf("leftover[%0d]", p), exp_q[p].size(), 0);
  endtask

  task automatic cfg(input int p, input int len, input int prio, input int dest,
                     input int mode, input int pkts, input int gap);
    cfg_len[p]  = 9'(len);
    cfg_prio[p] = 3'(prio);
    cfg_dest[p] = 4'(dest);
    cfg_mode[p] = 2'(mode);
    cfg_pkts[p] = 16'(pkts);
    cfg_gap[p]  = 4'(gap);
  endtask

  initial begin
    rst_n = 1'b0; start = '0; stop = '0; pause = '0; rmask = '0;
    cfg_len = '0; cfg_prio = '0; cfg_dest = '0; cfg_mode = '0; cfg_pkts = '0; cfg_gap = '0;
    for (int p = 0; p < NP; p++) begin sop_prev[p] = -1; sop_gap[p] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_vld", wr_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", sent_cnt, 0);

    // Single packet right after reset release; a second start while busy is ignored
    rst_n = 1'b1;
    cfg(0, 3, 4, 3, 0, 1, 0);
    expect_pkts(0, 1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("p0_sop", wr_sop[0], 1);
    chk("p0_sop_vld", wr_vld[0], 0);
    chk("p0_busy", busy[0], 1);
    tick();
    chk("p0_hdr", wr_data[0], (3 << 7) | (4 << 4) | 3);
    chk("p0_hdr_vld", wr_vld[0], 1);
    tick();
    chk("p0_w0", wr_data[0], 0);
    start[0] = 1'b1; cfg_len[0] = 9'd7;
    tick();
    start[0] = 1'b0; cfg_len[0] = 9'd3;
    chk("p0_w1", wr_data[0], 1);
    tick();
    chk("p0_w2", wr_data[0], 2);
    tick();
    chk("p0_eop", wr_eop[0], 1);
    chk("p0_eop_vld", wr_vld[0], 0);
    tick();
    chk("p0_idle", busy[0], 0);
    fin(0, 1);

    // Pause across word 1 of a five-word packet
    cfg(2, 5, 1, 6, 0, 1, 0);
    expect_pkts(2, 1);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    tick(); tick();
    chk("p2_w0", wr_data[2], 2 * 512);
    pause[2] = 1'b1;
    tick();
    chk("p2_paused_a", wr_vld[2], 0);
    tick();
    chk("p2_paused_b", wr_vld[2], 0);
    pause[2] = 1'b0;
    tick();
    chk("p2_w1", wr_data[2], 2 * 512 + 1);
    wait_idle(16'h0004, 50);
    fin(2, 1);

    // Three ports together, two packets each with a two-cycle gap
    for (int p = 0; p < 3; p++) begin
      cfg(p, p + 1, p, p + 5, 0, 2, 2);
      expect_pkts(p, 2);
      sop_prev[p] = -1;
    end
    start = 16'h0007; tick(); start = '0;
    wait_idle(16'h0007, 100);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("spacing[%0d]", p), sop_gap[p], 1 + 1 + (p + 1) + 1 + 2);
      fin(p, 2);
    end

    // Destination rotation wraps modulo 16
    cfg(1, 2, 0, 15, 1, 3, 0);
    expect_pkts(1, 3);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    wait_idle(16'h0002, 100);
    fin(1, 3);

    // Stop mid-data with unlimited packet count
    cfg(1, 4, 2, 9, 0, 0, 0);
    expect_pkts(1, 1);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    tick(); tick();
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;
    wait_idle(16'h0002, 100);
    fin(1, 1);

    // Randomized configs with random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int p = 3; p < 8; p++) begin
        cfg(p, $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3));
        expect_pkts(p, int'(cfg_pkts[p]));
      end
      start = 16'h00f8; rmask = 16'h00f8;
      tick();
      start = '0;
      wait_idle(16'h00f8, 2000);
      rmask = '0; pause = '0;
      for (int p = 3; p < 8; p++) fin(p, int'(cfg_pkts[p]));
    end

    // Asynchronous reset mid-data, then a clean restart
    cfg(0, 5, 3, 2, 0, 1, 0);
    expect_pkts(0, 1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_vld", wr_vld, 0);
    chk("arst_sop", wr_sop, 0);
    chk("arst_eop", wr_eop, 0);
    chk("arst_data", wr_data[0], 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", sent_cnt, 0);
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    tick();
    rst_n = 1'b1;
    expect_pkts(0, 1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("restart_sop", wr_sop[0], 1);
    wait_idle(16'h0001, 50);
    fin(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
